// File: rtl/frogg_button_cond_if.sv
// Button/paddle bundle for the frog button conditioner.
// The master side (board or bench) drives the raw switches and observes the
// debounced levels plus the hop pulse and direction. The slave side is the
// conditioner itself.
interface frogg_button_cond_if;
  logic       i_Switch_Up;
  logic       i_Switch_Dn;
  logic       i_Switch_Lt;
  logic       i_Switch_Rt;
  logic       o_Paddle_Up;
  logic       o_Paddle_Dn;
  logic       o_Paddle_lt;
  logic       o_Paddle_rt;
  logic       o_Hop;
  logic [1:0] o_Dir;

  modport master (
    output i_Switch_Up, i_Switch_Dn, i_Switch_Lt, i_Switch_Rt,
    input  o_Paddle_Up, o_Paddle_Dn, o_Paddle_lt, o_Paddle_rt, o_Hop, o_Dir
  );

  modport slave (
    input  i_Switch_Up, i_Switch_Dn, i_Switch_Lt, i_Switch_Rt,
    output o_Paddle_Up, o_Paddle_Dn, o_Paddle_lt, o_Paddle_rt, o_Hop, o_Dir
  );
endinterface

// File: rtl/frogg_button_cond.sv
// Frog button conditioner: four raw buttons are synchronized and debounced.
// They are reduced to mutually exclusive paddle levels, and a hop FSM emits
// one o_Hop pulse per press.
// Optional auto-repeat of hops while a single button is held is enabled by
// defining FROGG_BUTTON_AUTOREPEAT_EN. When it is undefined, the REPEAT state
// and the repeat counter do not exist.
// Lane order and direction code: 0 up, 1 down, 2 left, 3 right.

// One debounce lane: a 2-flop synchronizer feeding a stable-run counter.
module frogg_button_chan #(
  parameter int c_DEBOUNCE_LIMIT = 250000
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Raw,
  output logic o_Stable
);
  logic        meta_q, meta_d;
  logic        sync_q, sync_d;
  logic        stable_q, stable_d;
  logic [23:0] cnt_q, cnt_d;

  // Count consecutive cycles that disagree with the stable bit.
  // Accept the new level once the run reaches the limit.
  always_comb begin
    meta_d   = i_Raw;
    sync_d   = meta_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_q != stable_q) begin
      if (cnt_q == 24'(c_DEBOUNCE_LIMIT - 1)) stable_d = ~stable_q;
      else                                     cnt_d    = cnt_q + 24'd1;
    end
  end

  // Lane state registers.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= meta_d;
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_Stable = stable_q;
endmodule

module frogg_button_cond #(
  parameter int c_DEBOUNCE_LIMIT = 250000,
  parameter int c_REPEAT_DELAY   = 12500000,
  parameter int c_REPEAT_PERIOD  = 5000000
) (
  input logic               i_Clk,
  input logic               i_Rst,
  frogg_button_cond_if.slave bus
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0] raw, stable, level_q, level_d, dir_mask;
  logic                 one_hot;
  logic [1:0]           sel_dir;

  assign raw = {bus.i_Switch_Rt, bus.i_Switch_Lt, bus.i_Switch_Dn, bus.i_Switch_Up};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    frogg_button_chan #(.c_DEBOUNCE_LIMIT(c_DEBOUNCE_LIMIT)) u_chan (
      .i_Clk    (i_Clk),
      .i_Rst    (i_Rst),
      .i_Raw    (raw[g]),
      .o_Stable (stable[g])
    );
  end

  // Only a single pressed button is meaningful. A chord reads as nothing pressed.
  always_comb begin
    one_hot = $onehot(stable);
    level_d = one_hot ? stable : '0;
    case (stable)
      4'b0010: sel_dir = 2'd1;
      4'b0100: sel_dir = 2'd2;
      4'b1000: sel_dir = 2'd3;
      default: sel_dir = 2'd0;
    endcase
  end

  // Registered paddle levels. They assert on the same edge as the first hop.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) level_q <= '0;
    else       level_q <= level_d;
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1
`ifdef FROGG_BUTTON_AUTOREPEAT_EN
    , REPEAT = 2'd2
`endif
  } state_e;

  state_e     state_q;
  logic       hop_q;
  logic [1:0] dir_q;
  logic       lock_q;   // stable vector strayed from the latched button; wait for full release

  assign dir_mask = 4'b0001 << dir_q;

`ifdef FROGG_BUTTON_AUTOREPEAT_EN
  // A gap of at least two cycles keeps hop pulses from ever touching.
  localparam int REP_DLY = (c_REPEAT_DELAY  < 2) ? 2 : c_REPEAT_DELAY;
  localparam int REP_PER = (c_REPEAT_PERIOD < 2) ? 2 : c_REPEAT_PERIOD;
  localparam int REP_MAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  logic [REP_W-1:0] rep_q;
`endif

  // Hop FSM. The first hop fires from IDLE. Leaving HELD/REPEAT needs an all-zero vector.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= IDLE;
      hop_q   <= 1'b0;
      dir_q   <= 2'd0;
      lock_q  <= 1'b0;
`ifdef FROGG_BUTTON_AUTOREPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      hop_q <= 1'b0;
`ifdef FROGG_BUTTON_AUTOREPEAT_EN
      rep_q <= '0;
`endif
      case (state_q)
        IDLE: begin
          lock_q <= 1'b0;
          if (one_hot) begin
            hop_q   <= 1'b1;
            dir_q   <= sel_dir;
            state_q <= HELD;
          end
        end
        HELD: begin
          if (stable == '0) begin
            state_q <= IDLE;
            lock_q  <= 1'b0;
          end else if (lock_q || (stable != dir_mask)) begin
            lock_q <= 1'b1;
          end
`ifdef FROGG_BUTTON_AUTOREPEAT_EN
          else if (rep_q == REP_W'(REP_DLY - 1)) begin
            hop_q   <= 1'b1;
            state_q <= REPEAT;
          end else begin
            rep_q <= rep_q + 1'b1;
          end
`endif
        end
`ifdef FROGG_BUTTON_AUTOREPEAT_EN
        REPEAT: begin
          if (stable == '0) begin
            state_q <= IDLE;
          end else if (stable != dir_mask) begin
            lock_q  <= 1'b1;
            state_q <= HELD;
          end else if (rep_q == REP_W'(REP_PER - 1)) begin
            hop_q <= 1'b1;
          end else begin
            rep_q <= rep_q + 1'b1;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_Paddle_Up = level_q[0];
  assign bus.o_Paddle_Dn = level_q[1];
  assign bus.o_Paddle_lt = level_q[2];
  assign bus.o_Paddle_rt = level_q[3];
  assign bus.o_Hop       = hop_q;
  assign bus.o_Dir       = dir_q;
endmodule

// File: tb/tb_frogg_button_cond.sv
// Bench for frogg_button_cond (small debounce/repeat constants).
// The model below works from the timing rules. A button's accepted level
// flips when its raw samples, seen two clocks late, disagree with it for
// LIM samples in a row. Hops are tracked as arm/press/release events.
// Directed cases come first, followed by random button traffic.
module tb_frogg_button_cond;
  localparam int LIM = 4;
  localparam int DLY = 20;
  localparam int PER = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  frogg_button_cond_if bus();

  frogg_button_cond #(
    .c_DEBOUNCE_LIMIT (LIM),
    .c_REPEAT_DELAY   (DLY),
    .c_REPEAT_PERIOD  (PER)
  ) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0]  st_m = '0;
  logic [3:0]  lvl_m = '0;
  logic        hop_m = 1'b0;
  logic [1:0]  dir_m = '0;
  logic        armed = 1'b1;
  logic        blocked = 1'b0;
  logic [31:0] h [4];
`ifdef FROGG_BUTTON_AUTOREPEAT_EN
  int since = 0;
  int nrep = 0;
`endif

  function automatic bit single(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] pos(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
    return 2'd0;
  endfunction

  function automatic logic [3:0] sw_vec();
    return {bus.i_Switch_Rt, bus.i_Switch_Lt, bus.i_Switch_Dn, bus.i_Switch_Up};
  endfunction

  // Flip a lane when the LIM samples ending two clocks ago all disagree with it.
  function automatic logic [3:0] next_st(input logic [3:0] st);
    logic [3:0] r;
    r = st;
    for (int ch = 0; ch < 4; ch++) begin
      bit diff;
      diff = 1'b1;
      for (int k = 1; k <= LIM; k++) if (h[ch][k] == st[ch]) diff = 1'b0;
      if (diff) r[ch] = ~st[ch];
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      st_m <= '0; lvl_m <= '0; hop_m <= 1'b0; dir_m <= '0;
      armed <= 1'b1; blocked <= 1'b0;
`ifdef FROGG_BUTTON_AUTOREPEAT_EN
      since <= 0; nrep <= 0;
`endif
      for (int ch = 0; ch < 4; ch++) h[ch] <= '0;
    end else begin
      lvl_m <= single(st_m) ? st_m : 4'd0;
      hop_m <= 1'b0;
      if (armed) begin
        if (single(st_m)) begin
          hop_m <= 1'b1; dir_m <= pos(st_m); armed <= 1'b0; blocked <= 1'b0;
`ifdef FROGG_BUTTON_AUTOREPEAT_EN
          since <= 0; nrep <= 0;
`endif
        end
      end else if (st_m == 4'd0) begin
        armed <= 1'b1;
      end else if (blocked || (st_m != (4'b0001 << dir_m))) begin
        blocked <= 1'b1;
      end else begin
`ifdef FROGG_BUTTON_AUTOREPEAT_EN
        if (since + 1 == ((nrep == 0) ? DLY : PER)) begin
          hop_m <= 1'b1; since <= 0; nrep <= nrep + 1;
        end else begin
          since <= since + 1;
        end
`endif
      end
      st_m <= next_st(st_m);
      for (int ch = 0; ch < 4; ch++) h[ch] <= {h[ch][30:0], sw_vec()[ch]};
    end
  end

  // ---------------- per-cycle check and hop logging ----------------
  logic       run = 1'b0;
  logic       hop_prev = 1'b0;
  logic [3:0] lvl_seen = '0;
  int         t0 = 0;
  int         hop_t[$];
  int         hop_d[$];
  int         exp_q[$];

  wire [3:0] lvl_o = {bus.o_Paddle_rt, bus.o_Paddle_lt, bus.o_Paddle_Dn, bus.o_Paddle_Up};

  always @(negedge clk) begin
    if (run) begin
      chk("lvl", 32'(lvl_o), 32'(lvl_m));
      chk("hop", 32'(bus.o_Hop), 32'(hop_m));
      chk("dir", 32'(bus.o_Dir), 32'(dir_m));
      chk("hop_b2b", 32'(bus.o_Hop & hop_prev), 32'd0);
      hop_prev <= bus.o_Hop;
      lvl_seen <= lvl_seen | lvl_o;
      if (bus.o_Hop) begin
        hop_t.push_back(cyc - t0);
        hop_d.push_back(int'(bus.o_Dir));
      end
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic set_sw(input logic [3:0] v);
    bus.i_Switch_Up = v[0];
    bus.i_Switch_Dn = v[1];
    bus.i_Switch_Lt = v[2];
    bus.i_Switch_Rt = v[3];
  endtask

  task automatic clr();
    hop_t.delete();
    hop_d.delete();
    lvl_seen = '0;
    t0 = cyc;
  endtask

  // Compare logged hop times to exp_q. Every logged hop must carry direction dir.
  task automatic chk_list(input string tag, input int dir);
    chk({tag, "_n"}, hop_t.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < hop_t.size(); i++) begin
      chk({tag, "_t"}, hop_t[i], exp_q[i]);
      chk({tag, "_d"}, hop_d[i], dir);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    set_sw(4'd0);
    #1 rst = 1'b1;
    run = 1'b1;
    step(3);
    chk("rst_lvl", 32'(lvl_o), 32'd0);
    chk("rst_hop", 32'(bus.o_Hop), 32'd0);
    chk("rst_dir", 32'(bus.o_Dir), 32'd0);
    rst = 1'b0;
    step(5);

    // Clean Up press: level and hop at cycle 7
    clr(); set_sw(4'b0001);
    step(7);
    chk("up_lvl7", 32'(lvl_o), 32'b0001);
    step(33); set_sw(4'd0); step(15);
`ifdef FROGG_BUTTON_AUTOREPEAT_EN
    exp_q = {7, 27, 35, 43};
`else
    exp_q = {7};
`endif
    chk_list("up", 0);

    // Right chatters every 2 cycles: never accepted
    clr();
    for (int i = 0; i < 20; i++) begin
      set_sw(4'b1000); step(2);
      set_sw(4'b0000); step(2);
    end
    step(10);
    chk("chat_n", hop_t.size(), 0);
    chk("chat_lvl", 32'(lvl_seen), 32'd0);

    // Left held, then Up added: chord kills levels, no hop, full release re-arms
    clr(); set_sw(4'b0100);
    step(10); set_sw(4'b0101);
    step(7);
    chk("chord_lvl17", 32'(lvl_o), 32'd0);
    chk("chord_hop17", 32'(bus.o_Hop), 32'd0);
    step(13); set_sw(4'd0); step(15);
    exp_q = {7};
    chk_list("lt", 2);
    clr(); set_sw(4'b0010);
    step(12); set_sw(4'd0); step(12);
    exp_q = {7};
    chk_list("dn", 1);

    // Down held 60 cycles
    clr(); set_sw(4'b0010);
    step(60); set_sw(4'd0); step(15);
`ifdef FROGG_BUTTON_AUTOREPEAT_EN
    exp_q = {7, 27, 35, 43, 51, 59};
`else
    exp_q = {7};
`endif
    chk_list("rep", 1);

    // Reset mid-press: abort, then debounce afresh after release
    clr(); set_sw(4'b0001);
    step(5); rst = 1'b1;
    step(1);
    chk("mid_rst_lvl", 32'(lvl_o), 32'd0);
    chk("mid_rst_hop", 32'(bus.o_Hop), 32'd0);
    chk("mid_rst_dir", 32'(bus.o_Dir), 32'd0);
    step(2); rst = 1'b0;
    step(15); set_sw(4'd0); step(15);
    exp_q = {15};
    chk_list("rst", 0);

    // Random traffic: calm, medium and bouncy segments, one async reset pulse
    for (int seg = 0; seg < 12; seg++) begin
      int pct;
      logic [3:0] v;
      case ($urandom_range(0, 2))
        0:       pct = 2;
        1:       pct = 6;
        default: pct = 30;
      endcase
      if (seg == 6) begin
        rst = 1'b1; step(2); rst = 1'b0;
      end
      v = sw_vec();
      for (int i = 0; i < 100; i++) begin
        for (int ch = 0; ch < 4; ch++)
          if ($urandom_range(0, 99) < pct) v[ch] = ~v[ch];
        if ($urandom_range(0, 49) == 0) v = 4'd0;
        set_sw(v);
        step(1);
      end
    end
    set_sw(4'd0);
    step(20);
    run = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/frogg_button_cond.md
FROGG_BUTTON_COND -- requirements
Module: frogg_button_cond

Interface
REQ-001 Parameter c_DEBOUNCE_LIMIT, default 250000, is the number of consecutive stable cycles needed to accept a button change (10 ms at 25 MHz); legal range 1 to 2^24-1.
REQ-002 Parameter c_REPEAT_DELAY, default 12500000, is the number of cycles from the first hop to the first auto-repeat hop.
REQ-003 Parameter c_REPEAT_PERIOD, default 5000000, is the number of cycles between later auto-repeat hops.
REQ-004 i_Clk  input  1  is the single clock; every flop is clocked on the rising edge.
REQ-005 i_Rst  input  1  is the reset: asynchronous, active-high.
REQ-006 i_Switch_Up, i_Switch_Dn, i_Switch_Lt, i_Switch_Rt  input  1 each  are raw, bouncy board buttons, asynchronous to i_Clk, active-high.
REQ-007 o_Paddle_Up, o_Paddle_Dn, o_Paddle_lt, o_Paddle_rt  output  1 each  are debounced, mutually exclusive levels that drive the frog paddle controller's direction inputs.
REQ-008 o_Hop  output  1  is a one-cycle pulse per accepted hop.
REQ-009 o_Dir  output  2  is the hop direction, valid while o_Hop=1, held otherwise: 00 up, 01 down, 10 left, 11 right.

Function
REQ-010 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-011 Each channel SHALL have a 24-bit counter and a stable bit.
- Counter clears on any cycle where the synchronized input equals the stable bit.
- Counter increments otherwise.
- When the counter reaches c_DEBOUNCE_LIMIT, the stable bit toggles and the counter clears.
REQ-012 A glitch shorter than c_DEBOUNCE_LIMIT cycles SHALL NOT change the stable bit.
REQ-013 The level outputs SHALL be registered copies of the stable vector when exactly one stable bit is high; all four SHALL be 0 otherwise (zero or 2+ pressed).
REQ-014 Latency from a clean raw edge to the level output SHALL be exactly c_DEBOUNCE_LIMIT+3 cycles.
REQ-015 The hop FSM SHALL have the states IDLE, HELD and REPEAT, with o_Hop and o_Dir registered.
REQ-016 In IDLE, when exactly one stable bit is high, the FSM SHALL:
- pulse o_Hop in the same cycle that the level output asserts;
- load o_Dir with that button's direction;
- go to HELD.
REQ-017 In HELD or REPEAT, an all-zero stable vector SHALL return the FSM to IDLE with no hop.
REQ-018 In HELD or REPEAT, if the stable vector differs from the latched single button (different button, or 2+ buttons), the FSM SHALL emit no hop, stop repeat timing and wait for all-zero before re-arming.
REQ-019 A new direction SHALL always require a full release; there SHALL be no direct HELD-to-hop transition on a button change.
REQ-020 o_Hop SHALL never be high on two consecutive cycles.

Reset
REQ-021 While i_Rst=1, all of the following SHALL be 0 and the FSM SHALL be in IDLE: synchronizer flops, counters, stable bits, level outputs, o_Hop and o_Dir.
REQ-022 Reset asserted mid-press SHALL abort without a hop.
REQ-023 A button still held when reset releases SHALL be debounced afresh and produce its first hop c_DEBOUNCE_LIMIT+3 cycles after reset deassertion.

Configuration
REQ-024 With the macro FROGG_BUTTON_AUTOREPEAT_EN defined, the FSM SHALL auto-repeat:
- in HELD, c_REPEAT_DELAY cycles after the first hop with the same button held, emit a hop with the same o_Dir and go to REPEAT;
- in REPEAT, emit a hop every c_REPEAT_PERIOD cycles while the same single button stays held;
- the repeat counter clears on every state exit.
REQ-025 Without FROGG_BUTTON_AUTOREPEAT_EN:
- REPEAT and the repeat counters SHALL not be synthesized;
- HELD SHALL only wait for release;
- exactly one hop SHALL be emitted per press;
- c_REPEAT_DELAY and c_REPEAT_PERIOD SHALL be ignored.

Verification (c_DEBOUNCE_LIMIT=4, c_REPEAT_DELAY=20, c_REPEAT_PERIOD=8)
REQ-026 Clean press of i_Switch_Up at cycle 0 -> o_Paddle_Up=1 and o_Hop=1 with o_Dir=00 at cycle 7; no other hop while held (macro off).
REQ-027 i_Switch_Rt toggling every 2 cycles for 40 cycles, then low -> outputs stay 0 and no hop throughout.
REQ-028 Hold Lt, then press Up 10 cycles later -> at cycle 7, hop with o_Dir=10; at cycle 17, all levels 0, no hop; release both, then press Dn -> hop with o_Dir=01.
REQ-029 Macro on, hold Dn 60 cycles -> hops at cycles 7, 27, 35, 43, 51, 59, each with o_Dir=01.
REQ-030 Hold Up, assert i_Rst at cycle 5 for 3 cycles -> no hop and all outputs 0 during reset; first hop 7 cycles after reset release.
